// File: rtl/msk_aes_inv_mc_serial.sv
// msk_aes_inv_mc_serial
//
// Masked AES InvMixColumns layer for the decryption datapath. A full masked
// state is captured, InvMixColumns is applied to each share independently
// (the layer is GF(2)-linear with no constant term, so shares never mix and
// no randomness is needed), and the result is handed out on a valid/ready
// handshake.
//
// Sharing: byte k (0..15) at [8*d*k +: 8*d]; bit j of share i at d*j+i
// within that byte. Column c = bytes 4c..4c+3, byte 4c is row 0.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input state valid
//   in_ready   unit can accept a state (IDLE only)
//   in_state   masked input state, 128*d bits
//   out_valid  result valid (DONE only)
//   out_ready  consumer accepts the result
//   out_state  masked InvMixColumns result, driven from the state buffer
//
// Build option INV_MC_PARALLEL_EN: when defined, all four columns are
// processed on the single BUSY cycle; otherwise one column per cycle.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for in_valid; in_ready=1
// BUSY  | applying InvMixColumns to the buffer (1 col/cycle serial)
// DONE  | result held on out_state with out_valid=1 until out_ready

module msk_aes_inv_mc_serial #(
   parameter int d = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [128*d-1:0] in_state,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [128*d-1:0] out_state
);

   localparam int CW = 32*d;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t             state;
   logic [128*d-1:0]   st_buf;
   logic [128*d-1:0]   buf_next;
`ifndef INV_MC_PARALLEL_EN
   logic [1:0]         col;
   logic [CW-1:0]      col_sel;
`endif

   function automatic logic [7:0] xt(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] m9(input logic [7:0] x);
      return xt(xt(xt(x))) ^ x;
   endfunction

   function automatic logic [7:0] m11(input logic [7:0] x);
      return xt(xt(xt(x))) ^ xt(x) ^ x;
   endfunction

   function automatic logic [7:0] m13(input logic [7:0] x);
      return xt(xt(xt(x))) ^ xt(xt(x)) ^ x;
   endfunction

   function automatic logic [7:0] m14(input logic [7:0] x);
      return xt(xt(xt(x))) ^ xt(xt(x)) ^ xt(x);
   endfunction

   // One masked column: each share is de-interleaved, transformed on its own
   // and re-interleaved, so share i of the result depends only on share i.
   function automatic logic [CW-1:0] inv_mc_col(input logic [CW-1:0] c);
      logic [7:0]    a [4];
      logic [7:0]    b [4];
      logic [CW-1:0] r;
      r = '0;
      for (int i = 0; i < d; i++) begin
         for (int k = 0; k < 4; k++)
            for (int j = 0; j < 8; j++)
               a[k][j] = c[8*d*k + d*j + i];
         b[0] = m14(a[0]) ^ m11(a[1]) ^ m13(a[2]) ^ m9(a[3]);
         b[1] = m9(a[0])  ^ m14(a[1]) ^ m11(a[2]) ^ m13(a[3]);
         b[2] = m13(a[0]) ^ m9(a[1])  ^ m14(a[2]) ^ m11(a[3]);
         b[3] = m11(a[0]) ^ m13(a[1]) ^ m9(a[2])  ^ m14(a[3]);
         for (int k = 0; k < 4; k++)
            for (int j = 0; j < 8; j++)
               r[8*d*k + d*j + i] = b[k][j];
      end
      return r;
   endfunction

`ifdef INV_MC_PARALLEL_EN
   always_comb begin
      buf_next = st_buf;
      for (int c = 0; c < 4; c++)
         buf_next[c*CW +: CW] = inv_mc_col(st_buf[c*CW +: CW]);
   end
`else
   // A single column instance, fed by a mux and written back in place.
   always_comb begin
      col_sel = '0;
      for (int c = 0; c < 4; c++)
         if (col == 2'(c))
            col_sel = st_buf[c*CW +: CW];
   end

   always_comb begin
      buf_next = st_buf;
      for (int c = 0; c < 4; c++)
         if (col == 2'(c))
            buf_next[c*CW +: CW] = inv_mc_col(col_sel);
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         st_buf    <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
`ifndef INV_MC_PARALLEL_EN
         col       <= 2'd0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  st_buf   <= in_state;
                  in_ready <= 1'b0;
                  state    <= BUSY;
`ifndef INV_MC_PARALLEL_EN
                  col      <= 2'd0;
`endif
               end
            end
            BUSY: begin
               st_buf <= buf_next;
`ifdef INV_MC_PARALLEL_EN
               state     <= DONE;
               out_valid <= 1'b1;
`else
               col <= col + 2'd1;
               if (col == 2'd3) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
               end
`endif
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign out_state = st_buf;

endmodule

// File: tb/tb_msk_aes_inv_mc_serial.sv
module tb_msk_aes_inv_mc_serial;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, in_ready, out_valid, out_ready;
   logic [255:0] in_state, out_state;
   logic         in_valid3, in_ready3, out_valid3, out_ready3;
   logic [383:0] in_state3, out_state3;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef INV_MC_PARALLEL_EN
   localparam int EXP_LAT = 1;
   localparam int EXP_GAP = 3;
`else
   localparam int EXP_LAT = 4;
   localparam int EXP_GAP = 6;
`endif

   msk_aes_inv_mc_serial #(.d(2)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
      .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state)
   );

   msk_aes_inv_mc_serial #(.d(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid3), .in_ready(in_ready3), .in_state(in_state3),
      .out_valid(out_valid3), .out_ready(out_ready3), .out_state(out_state3)
   );

   always #5 clk = ~clk;

   // ---------------- reference model (plain bytes, byte 0 = MSB of literal)
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   function automatic logic [127:0] mc_plain(input logic [127:0] v, input bit inv);
      logic [127:0] r;
      logic [7:0]   a [4];
      logic [7:0]   k [4];
      if (inv) begin k[0] = 8'h0e; k[1] = 8'h0b; k[2] = 8'h0d; k[3] = 8'h09; end
      else     begin k[0] = 8'h02; k[1] = 8'h03; k[2] = 8'h01; k[3] = 8'h01; end
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int rw = 0; rw < 4; rw++) a[rw] = v[127-32*c-8*rw -: 8];
         for (int rw = 0; rw < 4; rw++)
            r[127-32*c-8*rw -: 8] = gmul(a[0], k[(4-rw)%4]) ^ gmul(a[1], k[(5-rw)%4])
                                  ^ gmul(a[2], k[(6-rw)%4]) ^ gmul(a[3], k[(7-rw)%4]);
      end
      return r;
   endfunction

   function automatic logic [127:0] get_share(input logic [383:0] x, input int dd, input int s);
      logic [127:0] r;
      for (int k = 0; k < 16; k++)
         for (int j = 0; j < 8; j++)
            r[120-8*k+j] = x[8*dd*k + dd*j + s];
      return r;
   endfunction

   function automatic logic [383:0] set_share(input logic [383:0] x, input int dd, input int s,
                                              input logic [127:0] v);
      logic [383:0] r;
      r = x;
      for (int k = 0; k < 16; k++)
         for (int j = 0; j < 8; j++)
            r[8*dd*k + dd*j + s] = v[120-8*k+j];
      return r;
   endfunction

   function automatic logic [255:0] mask2(input logic [127:0] v, input logic [127:0] m);
      logic [383:0] x;
      x = set_share('0, 2, 0, v ^ m);
      x = set_share(x, 2, 1, m);
      return x[255:0];
   endfunction

   function automatic logic [383:0] mc_masked(input logic [383:0] x, input int dd, input bit inv);
      logic [383:0] r;
      r = '0;
      for (int s = 0; s < dd; s++)
         r = set_share(r, dd, s, mc_plain(get_share(x, dd, s), inv));
      return r;
   endfunction

   task automatic check(input string name, input logic [383:0] got, input logic [383:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic run2(input logic [255:0] st, output logic [255:0] res, output int lat);
      int n;
      n = 0;
      while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
      in_valid = 1'b1;
      in_state = st;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      res = out_state;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic run3(input logic [383:0] st, output logic [383:0] res, output int lat);
      int n;
      n = 0;
      while (!in_ready3 && n < 20) begin @(posedge clk); #1; n++; end
      in_valid3 = 1'b1;
      in_state3 = st;
      @(posedge clk); #1;
      in_valid3 = 1'b0;
      lat = 0;
      while (!out_valid3 && lat < 20) begin @(posedge clk); #1; lat++; end
      res = out_state3;
      out_ready3 = 1'b1;
      @(posedge clk); #1;
      out_ready3 = 1'b0;
   endtask

   typedef struct {
      logic [127:0] pin;
      logic [127:0] mask;
      logic [127:0] pexp;
   } vec_t;

   initial begin
      vec_t         tbl [5];
      logic [255:0] st, res, snap, ea, eb;
      logic [383:0] x3, r3, back;
      logic [255:0] rres [2];
      int           acc_cyc [2];
      int           n_acc, n_res, lat, seen;
      bit           acc;

      tbl[0] = '{128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 128'h0,
                 128'hdb135345_f20a225c_01010101_c6c6c6c6};
      tbl[1] = '{128'h0, 128'h3a91c4e2_7f0055aa_12345678_9abcdef0, 128'h0};
      tbl[2] = '{128'hd5d5d7d6_4d7ebdf8_c6c6c6c6_8e4da1bc, 128'h5c0ffee1_deadbeef_a5a5a5a5_0f1e2d3c,
                 128'hd4d4d4d5_2d26314c_c6c6c6c6_db135345};
      tbl[3] = '{128'h01010101_9fdc589d_d5d5d7d6_4d7ebdf8, 128'hffffffff_00000000_13579bdf_2468ace0,
                 128'h01010101_f20a225c_d4d4d4d5_2d26314c};
      tbl[4] = '{128'hffffffff_c6c6c6c6_8e4da1bc_d5d5d7d6, 128'h87654321_0fedcba9_11223344_55667788,
                 128'hffffffff_c6c6c6c6_db135345_d4d4d4d5};

      rst_n = 1'b0;
      in_valid = 1'b0; in_state = '0; out_ready = 1'b0;
      in_valid3 = 1'b0; in_state3 = '0; out_ready3 = 1'b0;
      #22;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_state", out_state, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // table vectors: unmasked result, per-share result, latency
      for (int v = 0; v < 5; v++) begin
         st = mask2(tbl[v].pin, tbl[v].mask);
         run2(st, res, lat);
         check($sformatf("vec%0d_unmasked", v), get_share(res, 2, 0) ^ get_share(res, 2, 1), tbl[v].pexp);
         check($sformatf("vec%0d_shares", v), res, mc_masked(st, 2, 1'b1));
         check($sformatf("vec%0d_latency", v), lat, EXP_LAT);
         check($sformatf("vec%0d_drop", v), out_valid, 0);
      end

      // backpressure: hold DONE for 10 cycles with new input offered
      st = mask2(tbl[2].pin, tbl[2].mask);
      ea = mc_masked(st, 2, 1'b1);
      in_valid = 1'b1; in_state = st;
      @(posedge clk); #1;
      in_state = mask2(tbl[3].pin, tbl[3].mask);
      seen = 0;
      while (!out_valid && seen < 20) begin @(posedge clk); #1; seen++; end
      snap = out_state;
      check("bp_first_result", snap, ea);
      for (int i = 0; i < 10; i++) begin
         check("bp_out_valid", out_valid, 1);
         check("bp_in_ready", in_ready, 0);
         check("bp_out_state", out_state, snap);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bp_release_valid", out_valid, 0);
      check("bp_release_ready", in_ready, 1);

      // reset during the second BUSY cycle
      in_valid = 1'b1; in_state = mask2(tbl[4].pin, tbl[4].mask);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("rstmid_out_valid", out_valid, 0);
      check("rstmid_in_ready", in_ready, 1);
      check("rstmid_out_state", out_state, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (out_valid) seen++;
         @(posedge clk); #1;
      end
      check("rstmid_no_stale", seen, 0);
      st = mask2(tbl[3].pin, tbl[3].mask);
      run2(st, res, lat);
      check("rstmid_after", get_share(res, 2, 0) ^ get_share(res, 2, 1), tbl[3].pexp);

      // back-to-back with in_valid held high
      ea = mc_masked(mask2(tbl[0].pin, tbl[0].mask), 2, 1'b1);
      eb = mc_masked(mask2(tbl[2].pin, tbl[2].mask), 2, 1'b1);
      in_valid = 1'b1; in_state = mask2(tbl[0].pin, tbl[0].mask);
      out_ready = 1'b1;
      n_acc = 0; n_res = 0;
      acc_cyc[0] = 0; acc_cyc[1] = 0;
      rres[0] = '0; rres[1] = '0;
      for (int cyc = 0; cyc < 40 && n_res < 2; cyc++) begin
         acc = in_valid && in_ready;
         if (acc) begin acc_cyc[n_acc] = cyc; n_acc++; end
         if (out_valid) begin rres[n_res] = out_state; n_res++; end
         @(posedge clk); #1;
         if (acc && n_acc == 1) in_state = mask2(tbl[2].pin, tbl[2].mask);
         if (acc && n_acc == 2) in_valid = 1'b0;
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      check("b2b_accepts", n_acc, 2);
      check("b2b_results", n_res, 2);
      check("b2b_first", rres[0], ea);
      check("b2b_second", rres[1], eb);
      check("b2b_gap", acc_cyc[1] - acc_cyc[0], EXP_GAP);

      // round trip at d=3: forward MixColumns of the output recovers the input
      for (int t = 0; t < 1000; t++) begin
         for (int w = 0; w < 12; w++) x3[32*w +: 32] = $urandom;
         run3(x3, r3, lat);
         back = mc_masked(r3, 3, 1'b0);
         check($sformatf("rt3_%0d", t), back, x3);
      end
      check("rt3_latency", lat, EXP_LAT);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
